response_checker: RTL and testbench
===================================

Name: response_checker

Overview:
- Receiving end of the stimulus/response flow used by our chapter testbenches. A driver applies input vectors to a combinational unit and presents each applied vector, the unit's observed output, and the expected output. This block consumes those triples with a valid/ready handshake.
- It counts vectors and mismatches, captures the first failing vector, and reports pass/fail once the last vector is accepted.
- It is synthesizable, so it can also sit on-chip beside a self-test stimulus generator.

Parameters:
- IN_W, 3: width of the applied input vector ({A,B,C} ordering, A = MSB).
- CNT_W, 8: width of the vector/error counters and the captured index.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse: clear results and begin a run.
- vec_valid  input  1  driver has a triple on vec_in/dut_out/exp_out.
- vec_ready  output  1  checker accepts a triple this cycle.
- vec_in  input  IN_W  applied input vector.
- dut_out  input  1  observed unit output (F).
- exp_out  input  1  expected output.
- vec_last  input  1  qualifies the current triple as the final one of the run.
- busy  output  1  run in progress.
- done  output  1  run finished; results are stable.
- pass  output  1  run finished with zero mismatches and at least one vector.
- vec_count  output  CNT_W  vectors accepted this run.
- err_count  output  CNT_W  mismatches this run.
- first_err_vec  output  IN_W  vec_in of the first mismatch.
- first_err_idx  output  CNT_W  0-based index of the first mismatch.

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE. All outputs are 0, including vec_ready, counters and captured fields.
- FSM states: IDLE, RUN, DONE.
  - IDLE: vec_ready=0, busy=0, done=0. start=1 moves to RUN and clears vec_count, err_count, first_err_vec, first_err_idx and pass.
  - RUN: busy=1, vec_ready=1 (combinational from state only, no dependence on vec_valid).
  - DONE: done=1, busy=0, vec_ready=0. Results hold. start=1 re-enters RUN with all results cleared, exactly as from IDLE.
- Transfer occurs on a rising edge where vec_valid && vec_ready. Per transfer:
  - vec_count increments by 1. It saturates at 2^CNT_W-1 and never wraps.
  - A mismatch is dut_out != exp_out. On a mismatch, err_count increments, saturating at all-ones.
  - On a mismatch when err_count==0 (before the update), capture first_err_vec=vec_in and first_err_idx=vec_count (pre-increment value). Later mismatches never overwrite the capture.
  - If vec_last=1 on the transfer, the FSM moves to DONE on the same edge. pass is registered on that edge as (final err_count==0), which includes this transfer's result.
- Latency: counters and captured fields are visible one cycle after the accepting edge. done rises in the cycle after the last transfer.
- vec_last with vec_valid=0 is ignored. Inputs are ignored whenever no transfer occurs.
- start while in RUN is ignored; the run continues and counters are not cleared.
- start and a transfer on the same edge in DONE/IDLE: no transfer happens because vec_ready=0; only the start takes effect.
- A zero-vector run cannot end (DONE is only entered via vec_last). pass=0 unless at least one vector has been accepted.
- Back-to-back transfers are accepted every cycle; there are no bubbles.

Test Plan:
- Reset mid-run: start, 2 transfers, then assert reset asynchronously mid-cycle -> all outputs 0 immediately, FSM IDLE, vec_ready=0 before the next edge.
- Clean run: start, then vectors 3'b010 (dut=0, exp=0) and 3'b111 (dut=1, exp=1, last=1) on consecutive cycles -> vec_count=2, err_count=0, done=1, pass=1 one cycle after the second edge, vec_ready=0.
- First-error capture: 4 vectors 000, 011, 101, 110, with mismatches at index 1 and 3, last on 110 -> err_count=2, first_err_vec=3'b011, first_err_idx=1, pass=0.
- Handshake gaps and ignored start: vec_valid toggles 1,0,1,0,1 with last on the third valid, and start is pulsed during RUN -> vec_count=3, counters not cleared, vec_last on an invalid cycle ignored.
- Saturation: CNT_W=2 override, 6 mismatching vectors, last on the 6th -> vec_count=3, err_count=3, first_err_idx=0, no wrap.
- Rerun from DONE: after a failing run, pulse start -> counters and captures cleared next cycle, busy=1. A single matching vector with last -> pass=1, vec_count=1.

Source files
------------

// File: rtl/response_checker_if.sv
// Stimulus/response handshake bundle: the driver presents an applied vector,
// the observed unit output and the expected output.
interface response_checker_if #(
  parameter int IN_W = 3
);
  logic            vec_valid;
  logic            vec_ready;
  logic [IN_W-1:0] vec_in;
  logic            dut_out;
  logic            exp_out;
  logic            vec_last;

  modport master (
    output vec_valid, vec_in, dut_out, exp_out, vec_last,
    input  vec_ready
  );

  modport slave (
    input  vec_valid, vec_in, dut_out, exp_out, vec_last,
    output vec_ready
  );
endinterface

// File: rtl/response_checker.sv
// Response checker: consumes (vector, observed, expected) triples, tallies
// vectors and mismatches, captures the first failing vector and reports pass.
module response_checker #(
  parameter int IN_W  = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  response_checker_if.slave vec_if,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [IN_W-1:0]  first_err_vec,
  output logic [CNT_W-1:0] first_err_idx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [IN_W-1:0]  first_err_vec_q, first_err_vec_d;
  logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
  logic             pass_q, pass_d;

  logic ready_s, busy_s, done_s;
  logic xfer_s, mismatch_s, clear_s;

  assign xfer_s     = vec_if.vec_valid && ready_s;
  assign mismatch_s = vec_if.dut_out != vec_if.exp_out;
  // start only restarts from IDLE or DONE; a pulse during RUN is ignored
  assign clear_s    = start && (state_q != S_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
        else       state_d = S_IDLE;
      end
      S_RUN: begin
        if (xfer_s && vec_if.vec_last) state_d = S_DONE;
        else                           state_d = S_RUN;
      end
      S_DONE: begin
        if (start) state_d = S_RUN;
        else       state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_s = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_s = 1'b0;
      end
      S_RUN: begin
        ready_s = 1'b1;
        busy_s  = 1'b1;
      end
      S_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        ready_s = 1'b0;
      end
    endcase
  end

  always_comb begin
    vec_count_d     = vec_count_q;
    err_count_d     = err_count_q;
    first_err_vec_d = first_err_vec_q;
    first_err_idx_d = first_err_idx_q;
    pass_d          = pass_q;
    if (clear_s) begin
      vec_count_d     = CNT_ZERO;
      err_count_d     = CNT_ZERO;
      first_err_vec_d = {IN_W{1'b0}};
      first_err_idx_d = CNT_ZERO;
      pass_d          = 1'b0;
    end else if (xfer_s) begin
      if (vec_count_q != CNT_MAX) vec_count_d = vec_count_q + CNT_ONE;
      else                        vec_count_d = vec_count_q;
      if (mismatch_s) begin
        // capture index is the pre-increment count, i.e. 0-based
        if (err_count_q == CNT_ZERO) begin
          first_err_vec_d = vec_if.vec_in;
          first_err_idx_d = vec_count_q;
        end else begin
          first_err_vec_d = first_err_vec_q;
        end
        if (err_count_q != CNT_MAX) err_count_d = err_count_q + CNT_ONE;
        else                        err_count_d = err_count_q;
      end else begin
        err_count_d = err_count_q;
      end
      if (vec_if.vec_last) pass_d = (err_count_d == CNT_ZERO);
      else                 pass_d = pass_q;
    end else begin
      pass_d = pass_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_count_q     <= CNT_ZERO;
      err_count_q     <= CNT_ZERO;
      first_err_vec_q <= {IN_W{1'b0}};
      first_err_idx_q <= CNT_ZERO;
      pass_q          <= 1'b0;
    end else begin
      vec_count_q     <= vec_count_d;
      err_count_q     <= err_count_d;
      first_err_vec_q <= first_err_vec_d;
      first_err_idx_q <= first_err_idx_d;
      pass_q          <= pass_d;
    end
  end

  assign vec_if.vec_ready = ready_s;
  assign busy             = busy_s;
  assign done             = done_s;
  assign pass             = pass_q;
  assign vec_count        = vec_count_q;
  assign err_count        = err_count_q;
  assign first_err_vec    = first_err_vec_q;
  assign first_err_idx    = first_err_idx_q;

endmodule

// File: tb/tb_response_checker.sv
// Scoreboard bench for response_checker: a default instance plus a CNT_W=2
// instance for saturation; expected run results are queued at the last vector.
module tb_response_checker;

  localparam int IN_W = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  response_checker_if #(.IN_W(IN_W)) if0 ();
  response_checker_if #(.IN_W(IN_W)) if1 ();

  logic            start0, busy0, done0, pass0;
  logic [7:0]      vc0, ec0, fei0;
  logic [IN_W-1:0] fev0;
  logic            start1, busy1, done1, pass1;
  logic [1:0]      vc1, ec1, fei1;
  logic [IN_W-1:0] fev1;

  response_checker #(.IN_W(IN_W), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start0), .vec_if(if0),
    .busy(busy0), .done(done0), .pass(pass0),
    .vec_count(vc0), .err_count(ec0),
    .first_err_vec(fev0), .first_err_idx(fei0)
  );

  response_checker #(.IN_W(IN_W), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .start(start1), .vec_if(if1),
    .busy(busy1), .done(done1), .pass(pass1),
    .vec_count(vc1), .err_count(ec1),
    .first_err_vec(fev1), .first_err_idx(fei1)
  );

  typedef struct {
    int sel; int vc; int ec; int fev; int fei; int pass;
  } res_t;
  res_t exp_q[$];

  int n_run  = 0;
  int n_fail = 0;

  int m_vc[2], m_ec[2], m_fev[2], m_fei[2], m_st[2], m_pass[2];
  int mx[2] = '{255, 3};

  task automatic check_eq(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int g_ready(input int s); return s ? int'(if1.vec_ready) : int'(if0.vec_ready); endfunction
  function automatic int g_busy(input int s);  return s ? int'(busy1) : int'(busy0); endfunction
  function automatic int g_done(input int s);  return s ? int'(done1) : int'(done0); endfunction
  function automatic int g_pass(input int s);  return s ? int'(pass1) : int'(pass0); endfunction
  function automatic int g_vc(input int s);    return s ? int'(vc1) : int'(vc0); endfunction
  function automatic int g_ec(input int s);    return s ? int'(ec1) : int'(ec0); endfunction
  function automatic int g_fev(input int s);   return s ? int'(fev1) : int'(fev0); endfunction
  function automatic int g_fei(input int s);   return s ? int'(fei1) : int'(fei0); endfunction

  task automatic set_vec(input int s, input logic valid, input logic [IN_W-1:0] v,
                         input logic d, input logic e, input logic last);
    if (s == 0) begin
      if0.vec_valid = valid; if0.vec_in = v; if0.dut_out = d; if0.exp_out = e; if0.vec_last = last;
    end else begin
      if1.vec_valid = valid; if1.vec_in = v; if1.dut_out = d; if1.exp_out = e; if1.vec_last = last;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_vc[s] = 0; m_ec[s] = 0; m_fev[s] = 0; m_fei[s] = 0; m_st[s] = 0; m_pass[s] = 0;
    end
  endtask

  task automatic check_all(input int s, input string tag);
    check_eq({tag, "_ready"}, g_ready(s), (m_st[s] == 1) ? 1 : 0);
    check_eq({tag, "_busy"},  g_busy(s),  (m_st[s] == 1) ? 1 : 0);
    check_eq({tag, "_done"},  g_done(s),  (m_st[s] == 2) ? 1 : 0);
    check_eq({tag, "_pass"},  g_pass(s),  m_pass[s]);
    check_eq({tag, "_vc"},    g_vc(s),    m_vc[s]);
    check_eq({tag, "_ec"},    g_ec(s),    m_ec[s]);
    check_eq({tag, "_fev"},   g_fev(s),   m_fev[s]);
    check_eq({tag, "_fei"},   g_fei(s),   m_fei[s]);
  endtask

  // Entered and left at a falling edge.
  task automatic pulse_start(input int s);
    if (s == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    if (s == 0) start0 = 1'b0; else start1 = 1'b0;
    if (m_st[s] != 1) begin
      m_vc[s] = 0; m_ec[s] = 0; m_fev[s] = 0; m_fei[s] = 0; m_pass[s] = 0; m_st[s] = 1;
    end
    check_all(s, "start");
  endtask

  task automatic send(input int s, input logic [IN_W-1:0] v, input logic d,
                      input logic e, input logic last);
    res_t r;
    check_eq("pre_ready", g_ready(s), (m_st[s] == 1) ? 1 : 0);
    set_vec(s, 1'b1, v, d, e, last);
    @(negedge clk);
    set_vec(s, 1'b0, v, d, e, 1'b0);
    if (m_st[s] == 1) begin
      if (d != e) begin
        if (m_ec[s] == 0) begin m_fev[s] = int'(v); m_fei[s] = m_vc[s]; end
        if (m_ec[s] < mx[s]) m_ec[s]++;
      end
      if (m_vc[s] < mx[s]) m_vc[s]++;
      if (last) begin
        m_st[s] = 2;
        m_pass[s] = (m_ec[s] == 0) ? 1 : 0;
        r = '{sel: s, vc: m_vc[s], ec: m_ec[s], fev: m_fev[s], fei: m_fei[s], pass: m_pass[s]};
        exp_q.push_back(r);
      end
    end
    check_eq("vc", g_vc(s), m_vc[s]);
    check_eq("ec", g_ec(s), m_ec[s]);
  endtask

  // Idle cycle with vec_valid low, optionally with a stray last and start.
  task automatic gap(input int s, input logic stray_last, input logic st);
    set_vec(s, 1'b0, 3'b101, 1'b1, 1'b0, stray_last);
    if (s == 0) start0 = st; else start1 = st;
    @(negedge clk);
    set_vec(s, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    if (s == 0) start0 = 1'b0; else start1 = 1'b0;
    check_eq("gap_vc", g_vc(s), m_vc[s]);
    check_eq("gap_busy", g_busy(s), 1);
  endtask

  task automatic expect_done(input int s);
    res_t r;
    int t = 0;
    while (g_done(s) == 0 && t < 20) begin @(negedge clk); t++; end
    if (g_done(s) == 0) begin
      check_eq("done_timeout", g_done(s), 1);
    end else if (exp_q.size() == 0) begin
      check_eq("sb_size", exp_q.size(), 1);
    end else begin
      r = exp_q.pop_front();
      check_eq("sb_sel",   s, r.sel);
      check_eq("sb_vc",    g_vc(s),  r.vc);
      check_eq("sb_ec",    g_ec(s),  r.ec);
      check_eq("sb_fev",   g_fev(s), r.fev);
      check_eq("sb_fei",   g_fei(s), r.fei);
      check_eq("sb_pass",  g_pass(s), r.pass);
      check_eq("sb_busy",  g_busy(s), 0);
      check_eq("sb_ready", g_ready(s), 0);
    end
  endtask

  initial begin
    int n;
    logic [IN_W-1:0] rv;
    logic rd, re;
    reset = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    set_vec(0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    set_vec(1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all(0, "rst");
    check_all(1, "rst1");
    reset = 1'b0;
    @(negedge clk);

    // reset asserted mid-cycle during a run
    pulse_start(0);
    send(0, 3'b001, 1'b1, 1'b0, 1'b0);
    send(0, 3'b010, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all(0, "midrst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // clean run
    pulse_start(0);
    send(0, 3'b010, 1'b0, 1'b0, 1'b0);
    send(0, 3'b111, 1'b1, 1'b1, 1'b1);
    expect_done(0);

    // first-error capture
    pulse_start(0);
    send(0, 3'b000, 1'b0, 1'b0, 1'b0);
    send(0, 3'b011, 1'b1, 1'b0, 1'b0);
    send(0, 3'b101, 1'b1, 1'b1, 1'b0);
    send(0, 3'b110, 1'b0, 1'b1, 1'b1);
    check_eq("cap_vec", g_fev(0), 3);
    check_eq("cap_idx", g_fei(0), 1);
    expect_done(0);

    // rerun from DONE after a failing run
    pulse_start(0);
    send(0, 3'b100, 1'b1, 1'b1, 1'b1);
    expect_done(0);

    // handshake gaps, stray last, start ignored during RUN
    pulse_start(0);
    send(0, 3'b001, 1'b0, 1'b1, 1'b0);
    gap(0, 1'b1, 1'b1);
    send(0, 3'b010, 1'b1, 1'b1, 1'b0);
    gap(0, 1'b1, 1'b0);
    send(0, 3'b011, 1'b0, 1'b0, 1'b1);
    check_eq("gap_total", g_vc(0), 3);
    expect_done(0);

    // start while DONE coinciding with a valid triple: no transfer
    set_vec(0, 1'b1, 3'b111, 1'b1, 1'b0, 1'b1);
    pulse_start(0);
    set_vec(0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);

    // saturation on the narrow-counter instance
    pulse_start(1);
    for (int i = 0; i < 6; i++) send(1, 3'(i + 1), 1'b1, 1'b0, (i == 5) ? 1'b1 : 1'b0);
    expect_done(1);

    // randomized runs on the default instance
    for (int r = 0; r < 4; r++) begin
      if (m_st[0] == 1) send(0, 3'b000, 1'b0, 1'b0, 1'b1);
      if (exp_q.size() != 0) expect_done(0);
      pulse_start(0);
      n = $urandom_range(12, 1);
      for (int i = 0; i < n; i++) begin
        rv = 3'($urandom_range(7, 0));
        rd = 1'($urandom_range(1, 0));
        re = ($urandom_range(9, 0) < 3) ? ~rd : rd;
        send(0, rv, rd, re, (i == n - 1) ? 1'b1 : 1'b0);
      end
      expect_done(0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
